// File: rtl/lsu.sv
// Load/store unit: one outstanding access, lane alignment, load extension,
// misalignment detection and a WAIT-state timeout that reports a bus error.
module lsu #(
   parameter int CPU_WIDTH = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [CPU_WIDTH-1:0] i_addr,
   input  logic [CPU_WIDTH-1:0] i_wdata,
   input  logic                 i_we,
   input  logic [1:0]           i_size,
   input  logic                 i_unsigned,
   output logic                 o_mem_req,
   output logic                 o_mem_we,
   output logic [CPU_WIDTH-1:0] o_mem_addr,
   output logic [CPU_WIDTH-1:0] o_mem_wdata,
   output logic [3:0]           o_mem_wstrb,
   input  logic                 i_mem_gnt,
   input  logic                 i_mem_rvalid,
   input  logic [CPU_WIDTH-1:0] i_mem_rdata,
   output logic                 o_valid,
   input  logic                 i_wb_ready,
   output logic [CPU_WIDTH-1:0] o_rdata,
   output logic                 o_misalign,
   output logic                 o_buserr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]           state_q, state_d;
   logic [CPU_WIDTH-1:0] addr_q, addr_d;
   logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
   logic                 we_q, we_d;
   logic [1:0]           size_q, size_d;
   logic                 uns_q, uns_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [CPU_WIDTH-1:0] rdata_q, rdata_d;
   logic                 mis_q, mis_d;
   logic                 berr_q, berr_d;

   logic                 mis_in;
   logic [CPU_WIDTH-1:0] shifted;
   logic [CPU_WIDTH-1:0] load_result;

   always_comb begin
      case (i_size)
         2'b00:   mis_in = 1'b0;
         2'b01:   mis_in = i_addr[0];
         2'b10:   mis_in = |i_addr[1:0];
         default: mis_in = 1'b1;
      endcase
   end

   // Selected bytes land at bit 0; extension is chosen by the captured size.
   always_comb begin
      shifted = i_mem_rdata >> {addr_q[1:0], 3'b000};
      case (size_q)
         2'b00:   load_result = uns_q ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_result = uns_q ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
         default: load_result = shifted;
      endcase
      if (we_q) load_result = '0;
   end

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      mis_d   = mis_q;
      berr_d  = berr_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               addr_d  = i_addr;
               wdata_d = i_wdata;
               we_d    = i_we;
               size_d  = i_size;
               uns_d   = i_unsigned;
               rdata_d = '0;
               berr_d  = 1'b0;
               mis_d   = mis_in;
               state_d = mis_in ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            if (i_mem_gnt) begin
               cnt_d = 8'd0;
               if (i_mem_rvalid) begin
                  rdata_d = load_result;
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // A response arriving on the last allowed cycle still wins over the timeout.
            if (i_mem_rvalid) begin
               rdata_d = load_result;
               state_d = S_RESP;
            end else if (cnt_q == TO_LAST) begin
               rdata_d = '0;
               berr_d  = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            if (i_wb_ready) state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments; all capture registers are reset so no stale request leaks out.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         cnt_q   <= 8'd0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   assign o_ready    = (state_q == S_IDLE);
   assign o_mem_req  = (state_q == S_REQ);
   assign o_mem_we   = o_mem_req & we_q;
   assign o_mem_addr = {addr_q[CPU_WIDTH-1:2], 2'b00};

   always_comb begin
      case (size_q)
         2'b00: begin
            o_mem_wdata = {4{wdata_q[7:0]}};
            o_mem_wstrb = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            o_mem_wdata = {2{wdata_q[15:0]}};
            o_mem_wstrb = 4'b0011 << addr_q[1:0];
         end
         default: begin
            o_mem_wdata = wdata_q;
            o_mem_wstrb = 4'b1111;
         end
      endcase
      if (!o_mem_we) o_mem_wstrb = 4'b0000;
   end

   assign o_valid    = (state_q == S_RESP);
   assign o_rdata    = o_valid ? rdata_q : '0;
   assign o_misalign = o_valid & mis_q;
   assign o_buserr   = o_valid & berr_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed corner cases followed by randomized
// transactions, each compared against a byte-level reference model.
module tb_lsu;

   localparam int TIMEOUT_P = 4;

   logic        i_clk, i_rst;
   logic        i_valid, o_ready;
   logic [31:0] i_addr, i_wdata;
   logic        i_we;
   logic [1:0]  i_size;
   logic        i_unsigned;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_wstrb;
   logic        i_mem_gnt, i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_valid, i_wb_ready;
   logic [31:0] o_rdata;
   logic        o_misalign, o_buserr;

   int checks = 0;
   int errors = 0;

   lsu #(.CPU_WIDTH(32), .TIMEOUT(TIMEOUT_P)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we),
      .i_size(i_size), .i_unsigned(i_unsigned),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
      .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
      .o_valid(o_valid), .i_wb_ready(i_wb_ready),
      .o_rdata(o_rdata), .o_misalign(o_misalign), .o_buserr(o_buserr)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic        mis;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [3:0]  strb;
      logic [31:0] rdata;
   } exp_t;

   // Expected behaviour from the access rules, working byte by byte.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd,
                                  input logic we, input logic [1:0] sz,
                                  input logic uns, input logic [31:0] rd);
      exp_t e;
      int nb, off;
      logic [31:0] v;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off = int'(a[1:0]);
      e.mis    = (sz == 2'd3) || (off % nb != 0);
      e.maddr  = a & 32'hFFFF_FFFC;
      e.mwdata = '0;
      e.strb   = '0;
      for (int k = 0; k < 4; k++) begin
         e.mwdata[8*k +: 8] = wd[8*(k % nb) +: 8];
         e.strb[k] = we && !e.mis && (k >= off) && (k < off + nb);
      end
      v = '0;
      if (!e.mis) begin
         for (int j = 0; j < nb; j++) v[8*j +: 8] = rd[8*(off + j) +: 8];
         if (!uns && nb < 4 && v[8*nb - 1])
            for (int j = nb; j < 4; j++) v[8*j +: 8] = 8'hFF;
      end
      e.rdata = (we || e.mis) ? 32'd0 : v;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   // gd: grant stall cycles; n: 0 = rvalid with gnt, else rvalid in n-th WAIT cycle
   // (n > TIMEOUT_P means never); wbd: cycles of writeback backpressure.
   task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic [1:0] sz, input logic uns,
                      input int gd, input int n, input int wbd);
      exp_t e;
      logic [31:0] rd;
      logic timed_out;
      rd = $urandom;
      e  = model(a, wd, we, sz, uns, rd);
      timed_out = !e.mis && (n > TIMEOUT_P);
      for (int i = 0; i < 10 && !o_ready; i++) step();
      check("ready_idle", 32'(o_ready), 32'd1);
      i_valid = 1'b1; i_addr = a; i_wdata = wd; i_we = we; i_size = sz; i_unsigned = uns;
      step();
      i_valid = 1'b0; i_addr = $urandom; i_wdata = $urandom;
      i_we = 1'($urandom); i_size = 2'($urandom); i_unsigned = 1'($urandom);
      check("ready_busy", 32'(o_ready), 32'd0);
      if (!e.mis) begin
         for (int i = 0; i <= gd; i++) begin
            check("mem_req", 32'(o_mem_req), 32'd1);
            check("mem_addr", o_mem_addr, e.maddr);
            check("mem_we", 32'(o_mem_we), 32'(we));
            check("mem_wstrb", 32'(o_mem_wstrb), 32'(e.strb));
            if (we) check("mem_wdata", o_mem_wdata, e.mwdata);
            check("valid_early", 32'(o_valid), 32'd0);
            i_mem_gnt    = (i == gd);
            i_mem_rvalid = (i == gd) && (n == 0);
            i_mem_rdata  = i_mem_rvalid ? rd : $urandom;
            step();
         end
         i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
         for (int i = 1; i <= n && i <= TIMEOUT_P; i++) begin
            check("wait_req", 32'(o_mem_req), 32'd0);
            check("wait_valid", 32'(o_valid), 32'd0);
            i_mem_rvalid = (i == n);
            i_mem_rdata  = (i == n) ? rd : $urandom;
            step();
         end
         i_mem_rvalid = 1'b0;
      end else begin
         check("mis_no_req", 32'(o_mem_req), 32'd0);
      end
      for (int i = 0; i <= wbd; i++) begin
         check("resp_valid", 32'(o_valid), 32'd1);
         check("resp_rdata", o_rdata, timed_out ? 32'd0 : e.rdata);
         check("resp_misalign", 32'(o_misalign), 32'(e.mis));
         check("resp_buserr", 32'(o_buserr), 32'(timed_out));
         check("resp_ready", 32'(o_ready), 32'd0);
         check("resp_req", 32'(o_mem_req), 32'd0);
         i_wb_ready   = (i == wbd);
         i_mem_rvalid = 1'($urandom);
         i_mem_rdata  = $urandom;
         step();
      end
      i_wb_ready = 1'b0; i_mem_rvalid = 1'b0;
      check("done_valid", 32'(o_valid), 32'd0);
      check("done_ready", 32'(o_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(o_ready), 32'd1);
      check({tag, "_req"}, 32'(o_mem_req), 32'd0);
      check({tag, "_we"}, 32'(o_mem_we), 32'd0);
      check({tag, "_wstrb"}, 32'(o_mem_wstrb), 32'd0);
      check({tag, "_valid"}, 32'(o_valid), 32'd0);
      check({tag, "_rdata"}, o_rdata, 32'd0);
      check({tag, "_mis"}, 32'(o_misalign), 32'd0);
      check({tag, "_berr"}, 32'(o_buserr), 32'd0);
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_wdata = '0; i_we = 1'b0;
      i_size = 2'b00; i_unsigned = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
      i_mem_rdata = '0; i_wb_ready = 1'b0;
      #1;
      check_reset_outputs("rst0");
      step();
      step();
      i_rst = 1'b0;
      step();

      // Signed byte load from the top lane.
      txn(32'h8000_0003, 32'h0, 1'b0, 2'b00, 1'b0, 0, 0, 0);
      // Half store to upper lanes.
      txn(32'h0000_1002, 32'h0000_ABCD, 1'b1, 2'b01, 1'b0, 0, 1, 0);
      // Misaligned word and illegal size.
      txn(32'h0000_1001, 32'h1234_5678, 1'b0, 2'b10, 1'b0, 0, 0, 0);
      txn(32'h0000_1000, 32'h1234_5678, 1'b1, 2'b11, 1'b0, 0, 0, 1);
      // Grant stall, late response.
      txn(32'h0000_2004, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0, 3, 2, 0);
      // Response on the last allowed WAIT cycle, then a true timeout, then recovery.
      txn(32'h0000_3001, 32'h0, 1'b0, 2'b00, 1'b1, 0, TIMEOUT_P, 0);
      txn(32'h0000_3000, 32'h0, 1'b0, 2'b10, 1'b0, 0, TIMEOUT_P + 1, 0);
      txn(32'h0000_3002, 32'h0, 1'b0, 2'b01, 1'b0, 1, 1, 0);
      // Writeback backpressure.
      txn(32'h0000_4002, 32'h0, 1'b0, 2'b01, 1'b1, 0, 0, 5);

      // Reset pulsed while in WAIT abandons the access.
      i_valid = 1'b1; i_addr = 32'h0000_5000; i_we = 1'b1; i_size = 2'b10; i_wdata = 32'hCAFE_F00D;
      step();
      i_valid = 1'b0; i_mem_gnt = 1'b1;
      step();
      i_mem_gnt = 1'b0;
      step();
      i_rst = 1'b1;
      #1;
      check_reset_outputs("rst_wait");
      @(negedge i_clk);
      i_rst = 1'b0;
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
      step();
      step();
      i_mem_rvalid = 1'b0;
      check("late_rvalid_valid", 32'(o_valid), 32'd0);
      check("late_rvalid_ready", 32'(o_ready), 32'd1);
      check("late_rvalid_req", 32'(o_mem_req), 32'd0);
      // Counter must start fresh after reset.
      txn(32'h0000_6000, 32'h0, 1'b0, 2'b10, 1'b0, 0, TIMEOUT_P, 0);

      for (int t = 0; t < 60; t++) begin
         txn($urandom, $urandom, 1'($urandom), 2'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT_P + 1)),
             int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: CPU_WIDTH, 32, data/address width; only 32 is supported.
REQ-002 Parameter: TIMEOUT, 255, maximum cycles spent waiting in WAIT before a bus error is reported (range 1..255).
REQ-003 Port: i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: i_rst  input  1  asynchronous, active-high reset.
REQ-005 Port: i_valid  input  1  EXU request valid.
REQ-006 Port: o_ready  output  1  LSU can accept a request; high only in IDLE.
REQ-007 Port: i_addr  input  32  effective address, which is the ALU add result.
REQ-008 Port: i_wdata  input  32  store data (rs2).
REQ-009 Port: i_we  input  1  1 = store, 0 = load.
REQ-010 Port: i_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 Port: i_unsigned  input  1  1 = zero-extend load data, 0 = sign-extend.
REQ-012 Port: o_mem_req  output  1  memory request; held until granted.
REQ-013 Port: o_mem_we  output  1  memory write enable.
REQ-014 Port: o_mem_addr  output  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-015 Port: o_mem_wdata  output  32  lane-aligned store data.
REQ-016 Port: o_mem_wstrb  output  4  byte strobes; all zero for loads.
REQ-017 Port: i_mem_gnt  input  1  memory accepts the request this cycle.
REQ-018 Port: i_mem_rvalid  input  1  response/ack valid; used for loads and stores.
REQ-019 Port: i_mem_rdata  input  32  memory read data.
REQ-020 Port: o_valid  output  1  result valid to WBU; held until i_wb_ready.
REQ-021 Port: i_wb_ready  input  1  WBU accepts the result.
REQ-022 Port: o_rdata  output  32  aligned, extended load data; 0 for stores and errors.
REQ-023 Port: o_misalign  output  1  result is a misaligned/illegal-size fault; valid with o_valid.
REQ-024 Port: o_buserr  output  1  result is a timeout fault; valid with o_valid.

Function
REQ-025 The FSM SHALL have exactly the states IDLE, REQ, WAIT and RESP.
REQ-026 IDLE: i_valid && o_ready SHALL register addr, wdata, we, size and unsigned; aligned requests go to REQ, misaligned ones go to RESP with o_misalign=1.
REQ-027 Misalignment is defined as: half with addr[0]=1; word with addr[1:0]!=0; size 11 always misaligned; a misaligned request SHALL never assert o_mem_req.
REQ-028 REQ: o_mem_req=1 with stable addr/we/wdata/wstrb until i_mem_gnt; gnt without rvalid -> WAIT; gnt with rvalid in the same cycle -> RESP.
REQ-029 WAIT: i_mem_rvalid SHALL capture the result and go to RESP; rvalid outside REQ/WAIT SHALL be ignored.
REQ-030 Timeout: an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle; reaching TIMEOUT without rvalid -> RESP with o_buserr=1, o_rdata=0.
REQ-031 RESP: o_valid=1 with o_rdata/o_misalign/o_buserr stable; i_wb_ready -> IDLE on the next edge; o_ready stays 0 in RESP.
REQ-032 Minimum latency: accept in cycle N, gnt+rvalid in N+1, o_valid in N+2; back-to-back throughput is one access per 3 cycles.
REQ-033 Store lanes: byte -> wdata[7:0] replicated to all 4 lanes with wstrb=4'b0001<<addr[1:0]; half -> wdata[15:0] replicated with wstrb=4'b0011<<addr[1:0]; word -> wstrb=4'b1111.
REQ-034 Load data: shift rdata right by 8*addr[1:0], then extend byte/half from bit 7/15 per i_unsigned; word loads ignore i_unsigned.
REQ-035 Stores SHALL still wait for the rvalid acknowledge, and complete with o_rdata=0.
REQ-036 o_misalign and o_buserr SHALL never both be 1.

Reset
REQ-037 i_rst SHALL asynchronously force IDLE, clear the counter and capture registers, and drive o_mem_req, o_mem_we, o_mem_wstrb, o_valid, o_misalign and o_buserr to 0 and o_rdata to 0; o_ready SHALL be 1 while in reset.
REQ-038 Reset mid-transaction SHALL abandon the access with no response; a late rvalid after reset is ignored.

Verification
REQ-039 Load byte signed: addr=0x8000_0003, rdata=0x80FF_FF12 -> o_mem_addr=0x8000_0000, wstrb=0, o_rdata=0xFFFF_FF80.
REQ-040 Store half: addr=0x1002, wdata=0x0000_ABCD -> o_mem_wdata=0xABCD_ABCD, wstrb=4'b1100; ack -> o_valid, o_rdata=0.
REQ-041 Misaligned word: addr=0x1001, size=10 -> o_mem_req never 1, o_valid next cycle with o_misalign=1.
REQ-042 Grant stall: gnt low 3 cycles -> o_mem_req held 4 cycles with fields stable; rvalid 2 cycles later -> correct result.
REQ-043 Timeout: TIMEOUT=4, no rvalid -> o_buserr=1 after 4 WAIT cycles; a subsequent request completes normally.
REQ-044 Backpressure/reset: i_wb_ready low 5 cycles -> o_valid and data held, o_ready=0; i_rst pulsed in WAIT -> outputs 0 immediately, o_ready=1.
